// File: rtl/spi_slave_rx.sv
// SPI receive-side slave: oversamples SCK/MOSI in the clk_i domain, assembles
// MSB-first frames and queues them in a small FIFO behind a valid/ready port.
module spi_slave_rx #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int SAMPLE_EDGE  = 0,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sck_i,
    input  logic              mosi_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              overflow_o,
    input  logic              ovf_clr_i,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(DATA_W + 1);
    localparam int TO_W  = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DATA_W-1:0]      fifo_mem_q [FIFO_DEPTH];

    logic sck_s, mosi_s, sample_edge;
    logic push, push_ok, pop, full;

    // Both chains have identical depth so SCK/MOSI keep their relative timing.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sck_prev_d  = sck_s;
        sample_edge = (SAMPLE_EDGE != 0) ? (sck_s && !sck_prev_q)
                                         : (!sck_s && sck_prev_q);
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = to_cnt_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                if (sample_edge) begin
                    shift_d   = {shift_q[DATA_W-2:0], mosi_s};
                    bit_cnt_d = BC_W'(1);
                    state_d   = ST_RECV;
                end
            end
            ST_RECV: begin
                if (sample_edge) begin
                    shift_d  = {shift_q[DATA_W-2:0], mosi_s};
                    to_cnt_d = '0;
                    if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                        push      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end else if (to_cnt_q == TO_W'(IDLE_TIMEOUT - 1)) begin
                    // No chip select: a stalled partial frame is dropped to regain framing.
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    to_cnt_d    = '0;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop      = (count_q != '0) && rx_ready_i;
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Set beats clear when both land in the same cycle.
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage carries no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= shift_d;
        end
    end

    assign rx_valid_o  = (count_q != '0);
    assign rx_data_o   = rx_valid_o ? fifo_mem_q[rd_ptr_q] : '0;
    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q == ST_RECV);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: table of single-byte frames plus hand-written
// sequences for latency, overflow, full-with-pop, timeout, reset and rising-edge sampling.
module tb_spi_slave_rx;

    localparam int SYNC = 2;
    localparam int TO   = 64;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck, mosi, rx_ready, ovf_clr;
    logic [7:0] rx_data;
    logic       rx_valid, overflow, frame_err, busy;
    logic       sck_r, mosi_r, rx_ready_r, ovf_clr_r;
    logic [7:0] rx_data_r;
    logic       rx_valid_r, overflow_r, frame_err_r, busy_r;

    int checks = 0;
    int errors = 0;
    int ferr_total = 0;

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(SYNC),
                   .SAMPLE_EDGE(0), .IDLE_TIMEOUT(TO)) u_dut (
        .clk_i(clk), .reset_i(reset), .sck_i(sck), .mosi_i(mosi),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .overflow_o(overflow), .ovf_clr_i(ovf_clr), .frame_err_o(frame_err),
        .busy_o(busy));

    spi_slave_rx #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(SYNC),
                   .SAMPLE_EDGE(1), .IDLE_TIMEOUT(TO)) u_dut_r (
        .clk_i(clk), .reset_i(reset), .sck_i(sck_r), .mosi_i(mosi_r),
        .rx_data_o(rx_data_r), .rx_valid_o(rx_valid_r), .rx_ready_i(rx_ready_r),
        .overflow_o(overflow_r), .ovf_clr_i(ovf_clr_r), .frame_err_o(frame_err_r),
        .busy_o(busy_r));

    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_total++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // MOSI changes with SCK rising; the slave samples on the following fall.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(posedge clk); #1 sck = 1'b1; mosi = b[i];
            @(posedge clk); #1 sck = 1'b0;
        end
    endtask

    // Rising-edge variant: MOSI changes with SCK falling.
    task automatic send_bits_r(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            @(posedge clk); #1 sck_r = 1'b0; mosi_r = b[i];
            @(posedge clk); #1 sck_r = 1'b1;
        end
        @(posedge clk); #1 sck_r = 1'b0;
    endtask

    task automatic pop_one();
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
    endtask

    task automatic settle();
        repeat (SYNC + 3) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        logic [7:0] ovf_tx[5];
        logic [7:0] full_exp[4];
        int         lat, first;
        logic       found;
        logic [7:0] seen;

        vecs[0] = '{8'h01, 8'h01};
        vecs[1] = '{8'h80, 8'h80};
        vecs[2] = '{8'h6E, 8'h6E};
        vecs[3] = '{8'hC3, 8'hC3};
        vecs[4] = '{8'hFE, 8'hFE};
        vecs[5] = '{8'h5B, 8'h5B};
        ovf_tx   = '{8'h3C, 8'hFF, 8'h00, 8'h81, 8'h55};
        full_exp = '{8'h22, 8'h33, 8'h44, 8'h77};

        reset = 1'b1; sck = 1'b0; mosi = 1'b0; rx_ready = 1'b0; ovf_clr = 1'b0;
        sck_r = 1'b0; mosi_r = 1'b0; rx_ready_r = 1'b0; ovf_clr_r = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 reset = 1'b0;

        // 0xA5 with ready held high: latency and one-cycle valid
        rx_ready = 1'b1;
        send_bits(8'hA5, 8);
        lat = 0; found = 1'b0; seen = '0;
        for (int n = 1; n <= 10 && !found; n++) begin
            @(negedge clk);
            if (rx_valid) begin
                found = 1'b1; lat = n; seen = rx_data;
            end
        end
        check("a5_latency", lat, SYNC + 2);
        check("a5_data", seen, 8'hA5);
        @(negedge clk);
        check("a5_valid_1cyc", rx_valid, 0);
        check("a5_ovf", overflow, 0);
        $display("txn a5 latency=%0d data=%h", lat, seen);
        rx_ready = 1'b0;

        for (int v = 0; v < 6; v++) begin
            send_bits(vecs[v].tx, 8);
            settle();
            @(negedge clk);
            check("vec_valid", rx_valid, 1);
            check("vec_data", rx_data, vecs[v].exp_data);
            @(negedge clk);
            check("vec_hold", rx_data, vecs[v].exp_data);
            pop_one();
            @(negedge clk);
            check("vec_popped", rx_valid, 0);
            $display("txn vec %0d tx=%h rx=%h", v, vecs[v].tx, rx_data);
        end

        // Overflow: fifth byte into a four-entry FIFO is dropped
        for (int i = 0; i < 4; i++) send_bits(ovf_tx[i], 8);
        settle();
        @(negedge clk);
        check("ovf_at_full", overflow, 0);
        send_bits(ovf_tx[4], 8);
        settle();
        @(negedge clk);
        check("ovf_set", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ovf_rd_valid", rx_valid, 1);
            check("ovf_rd_data", rx_data, ovf_tx[i]);
            $display("txn ovf read %0d data=%h", i, rx_data);
            pop_one();
        end
        @(negedge clk);
        check("ovf_drained", rx_valid, 0);
        check("ovf_sticky", overflow, 1);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 0);

        // Full FIFO with a pop in the same cycle as the push of 0x77
        send_bits(8'h11, 8); send_bits(8'h22, 8); send_bits(8'h33, 8); send_bits(8'h44, 8);
        send_bits(8'h77, 8);
        repeat (SYNC) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        @(negedge clk);
        check("full_pop_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_rd_valid", rx_valid, 1);
            check("full_rd_data", rx_data, full_exp[i]);
            $display("txn full read %0d data=%h", i, rx_data);
            pop_one();
        end
        @(negedge clk);
        check("full_drained", rx_valid, 0);

        // Timeout on a 5-bit partial frame
        check("ferr_none_yet", ferr_total, 0);
        send_bits(8'hB8, 5);
        @(negedge clk);
        check("to_busy", busy, 1);
        first = 0;
        for (int n = 2; n <= 150; n++) begin
            @(negedge clk);
            if (frame_err && first == 0) first = n;
        end
        check("to_latency", first, SYNC + TO + 2);
        check("to_pulses", ferr_total, 1);
        check("to_busy_low", busy, 0);
        check("to_no_push", rx_valid, 0);
        $display("txn timeout at %0d", first);
        send_bits(8'h96, 8);
        settle();
        @(negedge clk);
        check("after_to_data", rx_data, 8'h96);
        pop_one();

        // Reset mid-frame with two bytes queued
        send_bits(8'h12, 8); send_bits(8'h34, 8);
        send_bits(8'hC3, 3);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", rx_valid, 1);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        check("arst_valid", rx_valid, 0);
        check("arst_data", rx_data, 0);
        check("arst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_empty", rx_valid, 0);
        send_bits(8'h5A, 8);
        settle();
        @(negedge clk);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_data", rx_data, 8'h5A);
        $display("txn post-reset data=%h", rx_data);
        pop_one();

        // Rising-edge sampling instance
        send_bits_r(8'hE1);
        settle();
        @(negedge clk);
        check("redge_valid", rx_valid_r, 1);
        check("redge_data", rx_data_r, 8'hE1);
        $display("txn rising-edge data=%h", rx_data_r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
Receive-side companion to the team's 8-bit SPI transmitter. The block sits directly downstream of the transmitter's SCK/MOSI pins and reconstructs MSB-first bytes by oversampling SCK and MOSI in the clk_i domain. Received bytes are buffered in a small FIFO and presented on a valid/ready interface. There is no chip-select line, so an inter-byte idle timeout resynchronises the framing.

Parameters:
DATA_W, 8, bits per frame; received MSB first.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, minimum 2.
SYNC_STAGES, 2, flip-flop stages on sck_i and mosi_i; minimum 2.
SAMPLE_EDGE, 0, 0 = sample MOSI on SCK falling edge, 1 = sample on rising edge.
IDLE_TIMEOUT, 64, clk_i cycles without a sample edge while mid-frame before the partial frame is discarded.

Ports:
clk_i  in  1  system clock
reset_i  in  1  reset; asynchronous, active-high
sck_i  in  1  serial clock from the master; idles low
mosi_i  in  1  serial data from the master
rx_data_o  out  DATA_W  FIFO head byte
rx_valid_o  out  1  FIFO not empty
rx_ready_i  in  1  consumer accept; pops when rx_valid_o && rx_ready_i
overflow_o  out  1  sticky flag: a completed byte was dropped because the FIFO was full
ovf_clr_i  in  1  clears overflow_o
frame_err_o  out  1  one-cycle pulse when a partial frame is discarded on timeout
busy_o  out  1  high while in RECV

Behaviour:
- Reset (async assert, sync release):
  - synchronisers and the previous-SCK register = 0; shift register = 0; bit counter = 0; timeout counter = 0.
  - FIFO empty; FSM = IDLE.
  - rx_data_o = 0, rx_valid_o = 0, overflow_o = 0, frame_err_o = 0, busy_o = 0.
  - Reset mid-frame discards the partial byte and all FIFO contents.
- Synchronisation and edge detection:
  - sck_i and mosi_i pass through identical SYNC_STAGES chains, so their relative alignment is preserved.
  - Sample edge = synced SCK transition selected by SAMPLE_EDGE, detected against a one-cycle-delayed copy.
  - Default SAMPLE_EDGE = 0 matches the transmitter, which updates MOSI on SCK rising.
- SCK timing: each sck_i phase must last at least 1 clk_i cycle when generated from clk_i, and at least 3 cycles when asynchronous.
- FSM:
  - IDLE: bit counter = 0. A sample edge shifts in bit 0 and moves to RECV with bit counter = 1.
  - RECV: each sample edge does shift_reg <= {shift_reg[DATA_W-2:0], mosi_sync} and increments the bit counter.
    - The edge that completes DATA_W bits issues a FIFO push of the assembled byte (including the current bit) and returns to IDLE.
    - If the timeout counter reaches IDLE_TIMEOUT-1 with no sample edge: pulse frame_err_o for 1 cycle, discard the partial byte, return to IDLE.
    - The timeout counter resets on every sample edge and counts only in RECV.
- Latency:
  - The FIFO write occurs at the end of the clk_i cycle in which the final sample edge is detected.
  - rx_valid_o (if the FIFO was empty) rises the next cycle.
  - From the sck_i pin edge this is SYNC_STAGES+2 cycles.
- FIFO:
  - rx_data_o shows the head entry; the read pointer advances on rx_valid_o && rx_ready_i.
  - Pointers wrap modulo FIFO_DEPTH; the count is tracked separately, with width clog2(FIFO_DEPTH)+1.
  - Push when full without a same-cycle pop: byte dropped, FIFO unchanged, overflow_o set.
  - Push when full with a same-cycle pop: accepted; the count stays at FIFO_DEPTH and no overflow is flagged.
  - Push and pop when empty: the push is accepted, the pop is ignored (rx_valid_o was 0).
  - rx_data_o is held stable while rx_valid_o=1 and rx_ready_i=0.
- overflow_o:
  - Sticky until ovf_clr_i.
  - If ovf_clr_i and a new overflow occur in the same cycle, the set wins.
- busy_o = (state == RECV).

Test Plan:
- Send 0xA5 with an SCK period of 2 clk_i and rx_ready_i=1 → rx_valid_o high for 1 cycle exactly SYNC_STAGES+2 cycles after the 8th falling edge; rx_data_o=0xA5; frame_err_o and overflow_o stay 0.
- Send 0x3C, 0xFF, 0x00, 0x81, 0x55 back-to-back with rx_ready_i=0 → after the 5th byte overflow_o=1. Then raise rx_ready_i → reads 0x3C, 0xFF, 0x00, 0x81, then rx_valid_o=0. Pulse ovf_clr_i → overflow_o=0.
- FIFO full; rx_ready_i=1 in the cycle 0x77 completes → 0x77 accepted as the last entry, overflow_o stays 0, 4 reads return the original 3 bytes plus 0x77.
- Send 5 bits, then hold SCK low for 64 cycles → frame_err_o pulses exactly once, busy_o falls, no FIFO push. A following full byte 0x96 is received as 0x96.
- Assert reset_i after 3 bits of 0xC3 with 2 bytes queued → all outputs 0 immediately, FIFO empty. After release, 0x5A is received correctly.
- SAMPLE_EDGE=1 with MOSI changing on SCK falling, send 0xE1 → rx_data_o=0xE1.
